// File: rtl/pw_trigger_seq.sv
// Multi-pulse trigger sequencer: after a match, emits a train of up to pNUM_PULSES
// pulses, each with its own delay and width, and gates capture for the whole train.
module pw_trigger_seq #(
  parameter int pNUM_PULSES  = 8,
  parameter int pDELAY_WIDTH = 20,
  parameter int pWIDTH_WIDTH = 17,
  parameter int pCNT_WIDTH   = $clog2(pNUM_PULSES + 1)
) (
  input  logic                                  fe_clk,
  input  logic                                  reset_i,
  input  logic [pNUM_PULSES*pDELAY_WIDTH-1:0]   I_delays,
  input  logic [pNUM_PULSES*pWIDTH_WIDTH-1:0]   I_widths,
  input  logic [pCNT_WIDTH-1:0]                 I_num_pulses,
  input  logic                                  I_match,
  input  logic                                  I_abort,
  input  logic                                  I_capturing,
  output logic                                  O_trigger,
  output logic                                  O_capture_enable,
  output logic                                  O_busy,
  output logic [pCNT_WIDTH-1:0]                 O_pulse_index,
  output logic                                  O_done
);

  localparam int CW = (pDELAY_WIDTH > pWIDTH_WIDTH) ? pDELAY_WIDTH : pWIDTH_WIDTH;
  localparam logic [pCNT_WIDTH-1:0] MAX_N = pCNT_WIDTH'(pNUM_PULSES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    HIGH  = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [pCNT_WIDTH-1:0]  idx_r, idx_s;
  logic [pCNT_WIDTH-1:0]  num_r, num_s;
  logic [pCNT_WIDTH:0]    idx_inc_s;
  logic                   done_s;
  logic                   trigger_r, busy_r, done_r, cap_en_r;
  logic [pDELAY_WIDTH-1:0] d0_s;

  function automatic logic [pDELAY_WIDTH-1:0] delay_of(
    input logic [pNUM_PULSES*pDELAY_WIDTH-1:0] vec,
    input logic [pCNT_WIDTH-1:0]               i
  );
    delay_of = '0;
    for (int k = 0; k < pNUM_PULSES; k++) begin
      if (int'(i) == k) delay_of = vec[k*pDELAY_WIDTH +: pDELAY_WIDTH];
    end
  endfunction

  // Width counter load value is max(W,1)-1 so a zero width still gives one high cycle.
  function automatic logic [CW-1:0] width_load(
    input logic [pNUM_PULSES*pWIDTH_WIDTH-1:0] vec,
    input logic [pCNT_WIDTH-1:0]               i
  );
    logic [pWIDTH_WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < pNUM_PULSES; k++) begin
      if (int'(i) == k) w = vec[k*pWIDTH_WIDTH +: pWIDTH_WIDTH];
    end
    if (w == '0) width_load = '0;
    else         width_load = CW'(w) - CW'(1);
  endfunction

  assign idx_inc_s = {1'b0, idx_r} + {{pCNT_WIDTH{1'b0}}, 1'b1};
  assign d0_s      = delay_of(I_delays, {pCNT_WIDTH{1'b0}});

  // Next-state logic. The match edge itself counts as the first low cycle of
  // pulse 0, so D0 low cycles follow it; later pulses get Di+1 low cycles.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    num_s   = num_r;
    done_s  = 1'b0;
    if (I_abort) begin
      state_s = IDLE;
      cnt_s   = '0;
      idx_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (I_match && (I_num_pulses != '0)) begin
            num_s = (I_num_pulses > MAX_N) ? MAX_N : I_num_pulses;
            idx_s = '0;
            if (d0_s == '0) begin
              state_s = HIGH;
              cnt_s   = width_load(I_widths, {pCNT_WIDTH{1'b0}});
            end else begin
              state_s = DELAY;
              cnt_s   = CW'(d0_s) - CW'(1);
            end
          end else begin
            state_s = IDLE;
          end
        end
        DELAY: begin
          if (cnt_r != '0) begin
            cnt_s = cnt_r - CW'(1);
          end else begin
            state_s = HIGH;
            cnt_s   = width_load(I_widths, idx_r);
          end
        end
        HIGH: begin
          if (cnt_r != '0) begin
            cnt_s = cnt_r - CW'(1);
          end else if (idx_inc_s < {1'b0, num_r}) begin
            state_s = DELAY;
            idx_s   = idx_inc_s[pCNT_WIDTH-1:0];
            cnt_s   = CW'(delay_of(I_delays, idx_inc_s[pCNT_WIDTH-1:0]));
          end else begin
            state_s = IDLE;
            idx_s   = '0;
            done_s  = 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = '0;
          idx_s   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      idx_r     <= '0;
      num_r     <= '0;
      trigger_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      cap_en_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      num_r     <= num_s;
      trigger_r <= (state_s == HIGH);
      busy_r    <= (state_s != IDLE);
      done_r    <= done_s;
      // Capture gate opens with the first pulse and closes once idle and capture ends.
      if (I_abort)                                   cap_en_r <= 1'b0;
      else if (state_s == HIGH)                      cap_en_r <= 1'b1;
      else if ((state_r == IDLE) && !I_capturing)    cap_en_r <= 1'b0;
      else                                           cap_en_r <= cap_en_r;
    end
  end

  assign O_trigger        = trigger_r;
  assign O_capture_enable = cap_en_r;
  assign O_busy           = busy_r;
  assign O_pulse_index    = idx_r;
  assign O_done           = done_r;

endmodule

// File: tb/tb_pw_trigger_seq.sv
// Directed bench for pw_trigger_seq: expected per-cycle outputs are derived from
// the pulse timing rules, queued when a train is launched, and popped each cycle.
module tb_pw_trigger_seq;

  localparam int NP = 8;
  localparam int DW = 20;
  localparam int WW = 17;
  localparam int CWD = $clog2(NP + 1);

  logic               fe_clk = 1'b0;
  logic               reset_i;
  logic [NP*DW-1:0]   I_delays;
  logic [NP*WW-1:0]   I_widths;
  logic [CWD-1:0]     I_num_pulses;
  logic               I_match, I_abort, I_capturing;
  logic               O_trigger, O_capture_enable, O_busy, O_done;
  logic [CWD-1:0]     O_pulse_index;

  pw_trigger_seq #(.pNUM_PULSES(NP), .pDELAY_WIDTH(DW), .pWIDTH_WIDTH(WW)) dut (
    .fe_clk(fe_clk), .reset_i(reset_i), .I_delays(I_delays), .I_widths(I_widths),
    .I_num_pulses(I_num_pulses), .I_match(I_match), .I_abort(I_abort),
    .I_capturing(I_capturing), .O_trigger(O_trigger), .O_capture_enable(O_capture_enable),
    .O_busy(O_busy), .O_pulse_index(O_pulse_index), .O_done(O_done)
  );

  always #5 fe_clk = ~fe_clk;

  typedef struct {
    logic trig;
    logic busy;
    logic done;
    logic cap;
    logic idx_chk;
    int   idx;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   dly[NP];
  int   wid[NP];
  logic cap_now = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic push_rec(input logic t, input logic b, input logic d, input logic c,
                          input logic ic, input int ix);
    rec_t r;
    r.trig = t; r.busy = b; r.done = d; r.cap = c; r.idx_chk = ic; r.idx = ix;
    exp_q.push_back(r);
  endtask

  task automatic push_idle(input logic c);
    push_rec(1'b0, 1'b0, 1'b0, c, 1'b0, 0);
  endtask

  // Reference timing: pulse 0 low D0 cycles after the match, pulse i>0 low Di+1
  // cycles, each high max(Wi,1) cycles, then one done cycle.
  task automatic push_train(input int n);
    int lo, hi;
    for (int i = 0; i < n; i++) begin
      lo = (i == 0) ? dly[i] : dly[i] + 1;
      hi = (wid[i] == 0) ? 1 : wid[i];
      for (int k = 0; k < lo; k++) push_rec(1'b0, 1'b1, 1'b0, cap_now, 1'b1, i);
      cap_now = 1'b1;
      for (int k = 0; k < hi; k++) push_rec(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, i);
    end
    push_rec(1'b0, 1'b0, 1'b1, cap_now, 1'b0, 0);
  endtask

  task automatic truncate(input int keep);
    while (exp_q.size() > keep) void'(exp_q.pop_back());
  endtask

  task automatic load_regs(input int n);
    for (int i = 0; i < NP; i++) begin
      I_delays[i*DW +: DW] = DW'(dly[i]);
      I_widths[i*WW +: WW] = WW'(wid[i]);
    end
    I_num_pulses = CWD'(n);
  endtask

  task automatic tick();
    rec_t e;
    @(posedge fe_clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("trigger", {31'd0, O_trigger}, {31'd0, e.trig});
      chk("busy", {31'd0, O_busy}, {31'd0, e.busy});
      chk("done", {31'd0, O_done}, {31'd0, e.done});
      chk("capture_enable", {31'd0, O_capture_enable}, {31'd0, e.cap});
      if (e.idx_chk) chk("pulse_index", 32'(O_pulse_index), 32'(e.idx));
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      tick();
      guard++;
    end
    chk("drain_bound", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset_i = 1'b1; I_match = 1'b0; I_abort = 1'b0; I_capturing = 1'b1;
    I_delays = '0; I_widths = '0; I_num_pulses = '0;
    for (int i = 0; i < NP; i++) begin dly[i] = 0; wid[i] = 0; end

    // Reset state: every output zero, index zero.
    push_rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    push_rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    tick(); tick();
    reset_i = 1'b0;
    repeat (8) push_idle(1'b0);
    drain();

    // Single pulse D0=0 W0=1, then capture falls while idle.
    dly[0] = 0; wid[0] = 1; load_regs(1);
    push_train(1);
    push_idle(1'b1); push_idle(1'b1);
    I_match = 1'b1; tick(); I_match = 1'b0;
    drain();
    push_idle(1'b0);
    I_capturing = 1'b0; tick(); I_capturing = 1'b1;
    cap_now = 1'b0;
    push_idle(1'b0);
    drain();

    // Three pulses D={5,0,2} W={3,0,4}, with a second match ignored during DELAY.
    dly[0] = 5; dly[1] = 0; dly[2] = 2; wid[0] = 3; wid[1] = 0; wid[2] = 4; load_regs(3);
    push_train(3);
    push_idle(1'b1);
    I_match = 1'b1; tick(); I_match = 1'b0;
    tick();
    I_match = 1'b1; tick(); I_match = 1'b0;
    drain();

    // Zero pulse count: no activity at all.
    load_regs(0);
    repeat (4) push_idle(cap_now);
    I_match = 1'b1; tick(); tick(); I_match = 1'b0;
    drain();

    // Pulse count above the maximum is clamped to NP pulses.
    dly = '{1, 0, 2, 0, 1, 0, 0, 3};
    wid = '{2, 1, 0, 3, 1, 2, 1, 1};
    load_regs(NP + 3);
    push_train(NP);
    push_idle(1'b1);
    I_match = 1'b1; tick(); I_match = 1'b0;
    drain();

    // Abort during pulse 1 HIGH, then a fresh train restarts at index 0.
    dly = '{1, 1, 1, 0, 0, 0, 0, 0};
    wid = '{2, 3, 2, 0, 0, 0, 0, 0};
    load_regs(3);
    push_train(3);
    truncate(6);
    push_rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    push_idle(1'b0);
    cap_now = 1'b0;
    I_match = 1'b1; tick(); I_match = 1'b0;
    repeat (5) tick();
    I_abort = 1'b1; tick(); I_abort = 1'b0;
    drain();
    push_train(3);
    push_idle(1'b1);
    I_match = 1'b1; tick(); I_match = 1'b0;
    drain();

    // Reset mid-pulse clears every output on the next edge.
    dly[0] = 0; wid[0] = 5; load_regs(1);
    push_train(1);
    truncate(2);
    push_rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    push_idle(1'b0);
    cap_now = 1'b0;
    I_match = 1'b1; tick(); I_match = 1'b0;
    tick();
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
